btn_debounce: RTL
=================

# btn_debounce

Pushbutton input conditioner for the 4-bit digital lock. It synchronizes the raw asynchronous button pins into the `clk` domain and debounces each button with its own counter. It emits a one-cycle press pulse per button, plus an encoded key strobe that the lock FSM consumes. It sits between the board pushbuttons and the lock FSM.

## Interface
- `N_BTN`, 4: number of buttons; `key_code` is sized for 4.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable synchronized samples required to accept a level change; must be ≥ 2.
- `CNT_W`, 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_raw`  in  N_BTN  raw pushbutton pins, asynchronous to `clk`.
- `btn_level`  out  N_BTN  debounced level; 1 = pressed.
- `btn_press`  out  N_BTN  one-cycle pulse per button on each accepted 0→1 transition.
- `key_valid`  out  1  one-cycle strobe; high when any `btn_press` bit is high.
- `key_code`  out  2  index of the lowest-numbered button pulsing in `btn_press`.
- `key_multi`  out  1  high with `key_valid` when more than one `btn_press` bit is high.

## Operation
- **Synchronizer.** Each input passes through a 2-flop synchronizer: `btn_raw` → `s1` → `s2`.
- **Per-button logic.** Each button has a counter `cnt[CNT_W-1:0]` and a registered stable state `stb`.
  - If `s2 == stb`: `cnt <= 0`.
  - If `s2 != stb` and `cnt == DEBOUNCE_CYCLES-1`: `stb <= s2` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
- **Glitch rejection.** A bounce back to `stb` before the counter expires clears `cnt`, so only an uninterrupted run of `DEBOUNCE_CYCLES` differing samples is accepted.
- **Counter range.** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it never wraps.
- **Outputs.**
  - `btn_level = stb`.
  - `btn_press[i]` is registered: it is high for exactly the one cycle in which `stb[i]` has just become 1.
  - Releases (1→0) update `btn_level` only; they produce no pulse.
- **Key encoder.** Registered in the same cycle as `btn_press`:
  - `key_valid = |btn_press`.
  - `key_code` = lowest set index of `btn_press`.
  - `key_multi = (popcount(btn_press) > 1)`.
  - When `key_valid` is 0, `key_code` holds 0.
- **Reset.** Asserting `reset` at any time clears `s1`, `s2`, `cnt`, `stb`, `btn_level`, `btn_press`, `key_valid`, `key_code` and `key_multi` to 0 immediately.
  - A button still held when reset deasserts is accepted as a new press after the normal latency.

## Timing
- **Reset values.** All outputs are 0.
- **Press latency.** `btn_raw[i]` rises and then stays stable from clock edge k. Then:
  - `s2` changes at edge k+2.
  - `btn_level[i]` and `btn_press[i]` rise at edge k+2+DEBOUNCE_CYCLES.
  - `key_valid`, `key_code` and `key_multi` are valid on that same edge.
- **Pulse width.** Exactly 1 cycle. The next pulse for the same button requires an accepted release followed by an accepted press, so the minimum spacing is 2·DEBOUNCE_CYCLES cycles.
- **Simultaneous events.** Buttons accepted on the same edge pulse together in `btn_press`; `key_code` and `key_multi` resolve them as defined above.
- **Other buttons.** Presses of different buttons on different edges give separate `key_valid` strobes; none are lost.

## Configuration
- `BTN_ACTIVE_LOW_EN`
  - **Defined:** `btn_raw` is inverted before the first synchronizer flop, for pull-up buttons where 0 = pressed. Reset still clears `s1`, `s2` and `stb` to 0, i.e. not pressed.
  - **Undefined:** `btn_raw` is active-high (1 = pressed).
  - Applies to all buttons.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4` and the `BTN_ACTIVE_LOW_EN` macro undefined unless stated.
- **Clean press.** Raise `btn_raw = 4'b0100` at edge 10 and hold → `btn_level[2]` and `btn_press[2]` rise at edge 16; `btn_press` is high for 1 cycle; `key_valid = 1`, `key_code = 2`, `key_multi = 0`.
- **Bounce.** Drive `btn_raw[0]` with the pattern 1,1,1,0,1,1,1,0 per cycle, then hold 1 → no pulse during the bouncing; exactly one `btn_press[0]` pulse 6 cycles after the final rise.
- **Simultaneous press and release.** Raise `btn_raw = 4'b1010` on the same edge → one pulse with `btn_press = 4'b1010`, `key_code = 1`, `key_multi = 1`. Release both → `btn_level` returns to 0 six cycles later with no pulse.
- **Reset mid-count.** Assert `reset` for 1 cycle while `cnt = 2` with the button held → all outputs are 0 immediately; after deassert, press is accepted 6 cycles later.
- **Active-low build.** With `BTN_ACTIVE_LOW_EN` defined, drive `btn_raw = 4'b1111` for 20 cycles, then `4'b1110` → no pulse before the change; after it, `btn_press[0]` pulses 6 cycles later with `key_code = 0`.

Source files
------------

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, per-button debounce counter, press pulse and key encoder.
// Define BTN_ACTIVE_LOW_EN for pull-up buttons (btn_raw inverted before the synchronizer).
module btn_debounce #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic             key_valid,
    output logic [1:0]       key_code,
    output logic             key_multi
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] s1_q, s2_q;
    logic [N_BTN-1:0] stb_q, stb_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic             valid_q, valid_d;
    logic             multi_q, multi_d;
    logic [1:0]       code_q, code_d;

`ifdef BTN_ACTIVE_LOW_EN
    assign btn_in = ~btn_raw;
`else
    assign btn_in = btn_raw;
`endif

    // A differing sample advances the counter; any sample equal to stb restarts it.
    always_comb begin
        stb_d = stb_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Encoder works on next-cycle press so all key outputs line up with btn_press.
    always_comb begin
        int unsigned ones;
        ones    = 0;
        press_d = stb_d & ~stb_q;
        valid_d = |press_d;
        code_d  = 2'd0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_d[i]) begin
                code_d = 2'(i);
                ones   = ones + 1;
            end
        end
        multi_d = (ones > 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            stb_q   <= '0;
            press_q <= '0;
            valid_q <= 1'b0;
            code_q  <= 2'd0;
            multi_q <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= btn_in;
            s2_q    <= s1_q;
            stb_q   <= stb_d;
            press_q <= press_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            multi_q <= multi_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level = stb_q;
    assign btn_press = press_q;
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_multi = multi_q;

endmodule
